// File: rtl/ps2_mouse_packet_decoder.sv
// PS/2 mouse stream decoder: assembles 3-byte packets from the receive path, decodes
// buttons, signed deltas and overflow flags, and tracks a clamped absolute cursor.
module ps2_mouse_packet_decoder #(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int POS_W          = 10,
    parameter int X_MAX          = 639,
    parameter int Y_MAX          = 479
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [7:0]       rx_byte,
    input  logic             rx_done,
    output logic             pkt_valid,
    output logic [2:0]       btn,
    output logic [8:0]       dx,
    output logic [8:0]       dy,
    output logic             x_ovf,
    output logic             y_ovf,
    output logic [POS_W-1:0] pos_x,
    output logic [POS_W-1:0] pos_y,
    output logic             sync_err
);

    typedef enum logic [1:0] {WAIT_B0, WAIT_B1, WAIT_B2} state_t;

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int SW = POS_W + 2;
    localparam logic [TW-1:0]        TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic signed [SW-1:0] X_LIM      = SW'(X_MAX);
    localparam logic signed [SW-1:0] Y_LIM      = SW'(Y_MAX);

    state_t          state_reg, state_next;
    logic [TW-1:0]   timer_reg, timer_next;
    // Header byte minus the always-one sync bit: {y_ovf, x_ovf, y_sign, x_sign, btn[2:0]}
    logic [6:0]      hdr_reg;
    logic [7:0]      byte1_reg;
    logic            latch_b0, latch_b1, commit, sync_next;

    logic [8:0]          pkt_dx, pkt_dy;
    logic signed [SW-1:0] sum_x, diff_y;
    logic [POS_W-1:0]    pos_x_next, pos_y_next;

    always_comb begin
        state_next = state_reg;
        timer_next = timer_reg;
        latch_b0   = 1'b0;
        latch_b1   = 1'b0;
        commit     = 1'b0;
        sync_next  = 1'b0;
        case (state_reg)
            WAIT_B0: begin
                timer_next = '0;
                if (rx_done) begin
                    if (rx_byte[3]) begin
                        latch_b0   = 1'b1;
                        state_next = WAIT_B1;
                    end else begin
                        sync_next = 1'b1;
                    end
                end
            end
            WAIT_B1, WAIT_B2: begin
                // A byte arriving in the expiry cycle takes priority over the timeout.
                if (rx_done) begin
                    timer_next = '0;
                    if (state_reg == WAIT_B1) begin
                        latch_b1   = 1'b1;
                        state_next = WAIT_B2;
                    end else begin
                        commit     = 1'b1;
                        state_next = WAIT_B0;
                    end
                end else if (timer_reg == TIMER_LAST) begin
                    timer_next = '0;
                    state_next = WAIT_B0;
                    sync_next  = 1'b1;
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end
            default: begin
                state_next = WAIT_B0;
                timer_next = '0;
            end
        endcase
    end

    assign pkt_dx = {hdr_reg[3], byte1_reg};
    assign pkt_dy = {hdr_reg[4], rx_byte};
    assign sum_x  = $signed({2'b00, pos_x}) + $signed({{(SW-9){pkt_dx[8]}}, pkt_dx});
    // Screen Y grows downward while mouse +Y is up, hence the subtraction.
    assign diff_y = $signed({2'b00, pos_y}) - $signed({{(SW-9){pkt_dy[8]}}, pkt_dy});

    always_comb begin
        pos_x_next = pos_x;
        pos_y_next = pos_y;
        if (!hdr_reg[5]) begin
            if (sum_x < 0)
                pos_x_next = '0;
            else if (sum_x > X_LIM)
                pos_x_next = POS_W'(X_MAX);
            else
                pos_x_next = sum_x[POS_W-1:0];
        end
        if (!hdr_reg[6]) begin
            if (diff_y < 0)
                pos_y_next = '0;
            else if (diff_y > Y_LIM)
                pos_y_next = POS_W'(Y_MAX);
            else
                pos_y_next = diff_y[POS_W-1:0];
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_reg <= WAIT_B0;
            timer_reg <= '0;
            hdr_reg   <= '0;
            byte1_reg <= '0;
            pkt_valid <= 1'b0;
            sync_err  <= 1'b0;
            btn       <= '0;
            dx        <= '0;
            dy        <= '0;
            x_ovf     <= 1'b0;
            y_ovf     <= 1'b0;
            pos_x     <= POS_W'(X_MAX >> 1);
            pos_y     <= POS_W'(Y_MAX >> 1);
        end else begin
            state_reg <= state_next;
            timer_reg <= timer_next;
            pkt_valid <= commit;
            sync_err  <= sync_next;
            if (latch_b0)
                hdr_reg <= {rx_byte[7:4], rx_byte[2:0]};
            if (latch_b1)
                byte1_reg <= rx_byte;
            if (commit) begin
                btn   <= hdr_reg[2:0];
                dx    <= pkt_dx;
                dy    <= pkt_dy;
                x_ovf <= hdr_reg[5];
                y_ovf <= hdr_reg[6];
                pos_x <= pos_x_next;
                pos_y <= pos_y_next;
            end
        end
    end

endmodule
